// File: rtl/hm_mult_sequencer.sv
// Sequencer for the homomorphic polynomial multiply engine: clears the engine,
// loads ciphertext A, accumulates ciphertext B, then drains the product.
module hm_mult_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] s_data,
    output logic                        mul_rst_n,
    output logic                        mul_en,
    output logic                        mul_select,
    output logic [DIMENSION:0]          mul_row,
    output logic [CIPHERTEXT_WIDTH-1:0] mul_entry,
    input  logic [CIPHERTEXT_WIDTH-1:0] mul_result,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] r_data,
    output logic [DIMENSION:0]          r_index,
    output logic                        r_last,
    output logic                        busy
);

    localparam int W  = CIPHERTEXT_WIDTH;
    localparam int RW = DIMENSION + 1;
    localparam logic [RW-1:0] LAST_IN  = RW'(DIMENSION);
    localparam logic [RW-1:0] LAST_OUT = RW'(2 * DIMENSION);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_A,
        LOAD_B,
        SETTLE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   cnt;
    logic [RW-1:0]   cnt_nxt;
    logic            accept;
    logic            fire;
    logic            rstn_nxt;
    logic            en_nxt;
    logic            sel_nxt;
    logic [RW-1:0]   row_nxt;
    logic [W-1:0]    entry_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (s_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD_A;
            LOAD_A:  if (s_valid && cnt == LAST_IN) state_nxt = LOAD_B;
            LOAD_B:  if (s_valid && cnt == LAST_IN) state_nxt = SETTLE;
            SETTLE:  state_nxt = DRAIN;
            DRAIN:   if (r_ready && r_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_ready = (state == LOAD_A) || (state == LOAD_B);
    assign r_valid = (state == DRAIN);
    assign busy    = (state != IDLE);
    assign r_data  = mul_result;
    assign r_index = mul_row;
    assign r_last  = r_valid && (mul_row == LAST_OUT);
    assign accept  = s_valid && s_ready;
    assign fire    = r_valid && r_ready;

    // Next values of the registered engine-side signals.
    always_comb begin
        rstn_nxt  = 1'b1;
        en_nxt    = 1'b0;
        sel_nxt   = mul_select;
        row_nxt   = mul_row;
        entry_nxt = mul_entry;
        cnt_nxt   = cnt;
        unique case (state)
            CLEAR: begin
                rstn_nxt = 1'b0;
                cnt_nxt  = '0;
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    en_nxt    = 1'b1;
                    sel_nxt   = (state == LOAD_B);
                    row_nxt   = cnt;
                    entry_nxt = s_data;
                    cnt_nxt   = (cnt == LAST_IN) ? '0 : cnt + 1'b1;
                end
            end
            SETTLE: begin
                row_nxt = '0;
            end
            DRAIN: begin
                if (fire) begin
                    row_nxt = r_last ? '0 : mul_row + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_rst_n  <= 1'b0;
            mul_en     <= 1'b0;
            mul_select <= 1'b0;
            mul_row    <= '0;
            mul_entry  <= '0;
            cnt        <= '0;
        end else begin
            mul_rst_n  <= rstn_nxt;
            mul_en     <= en_nxt;
            mul_select <= sel_nxt;
            mul_row    <= row_nxt;
            mul_entry  <= entry_nxt;
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: doc/hm_mult_sequencer.md
Name: hm_mult_sequencer

Overview:
- Initiator/driver for the team's homomorphic polynomial multiply engine (the block with ciphertext_entry / row / ciphertext_select / en / result_partial).
- Accepts two ciphertexts (DIMENSION+1 coefficients each) on a valid/ready input stream and clears the engine.
- Loads ciphertext A, then streams ciphertext B for accumulation.
- Drains the 2*DIMENSION+1 product coefficients on a valid/ready output stream.
- Sits between the coefficient memory/DMA and the multiply engine.

Parameters:
- CIPHERTEXT_WIDTH, 10, coefficient width in bits.
- DIMENSION, 1, polynomial degree; each ciphertext has DIMENSION+1 coefficients, the product has 2*DIMENSION+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input coefficient valid.
- s_ready  out  1  input coefficient accepted when s_valid&&s_ready.
- s_data  in  CIPHERTEXT_WIDTH  input coefficient; order is A[0..D], then B[0..D].
- mul_rst_n  out  1  engine clear, active-low, registered.
- mul_en  out  1  engine write enable, registered.
- mul_select  out  1  0 = load A, 1 = accumulate B, registered.
- mul_row  out  DIMENSION+1  engine row index, registered.
- mul_entry  out  CIPHERTEXT_WIDTH  engine coefficient, registered.
- mul_result  in  CIPHERTEXT_WIDTH  engine result_partial, which is combinational from mul_row.
- r_valid  out  1  result coefficient valid.
- r_ready  in  1  downstream accepts the result.
- r_data  out  CIPHERTEXT_WIDTH  result coefficient; combinational passthrough of mul_result.
- r_index  out  DIMENSION+1  coefficient index of r_data (equals mul_row).
- r_last  out  1  high with index 2*DIMENSION.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-operation:
  - state=IDLE; mul_rst_n=0, mul_en=0, mul_select=0, mul_row=0, mul_entry=0.
  - r_valid=0, busy=0, counters=0.
  - Aborts any operation silently; mul_rst_n=0 keeps the engine cleared while reset is held.
- FSM states and transitions:
  - IDLE: s_ready=0, mul_rst_n=1. When s_valid=1, go to CLEAR. The beat is not consumed.
  - CLEAR: exactly 1 cycle; mul_rst_n=0 registered into the next cycle; mul_en=0. Then go to LOAD_A with cnt=0.
  - LOAD_A: s_ready=1.
    - On an accepted beat: next cycle mul_en=1, mul_select=0, mul_row=cnt, mul_entry=s_data; cnt++.
    - Cycle with no beat: next cycle mul_en=0 (gaps allowed).
    - After beat D is accepted: go to LOAD_B, cnt=0.
  - LOAD_B: same as LOAD_A but mul_select=1.
    - After beat D is accepted: go to SETTLE.
  - SETTLE: 1 cycle; the last B write is on the mul_* outputs and the engine accumulates at the end of this cycle.
    - Next cycle: mul_en=0, mul_row=0; go to DRAIN.
  - DRAIN: s_ready=0; r_valid=1; r_data=mul_result; r_index=mul_row; r_last=(mul_row==2*DIMENSION).
    - On r_valid&&r_ready with r_last=0: mul_row++.
    - On r_valid&&r_ready with r_last=1: go to IDLE, r_valid=0, mul_row=0.
    - r_ready=0 holds mul_row and r_data stable.
- Latency:
  - Accepted beat -> mul_* outputs: 1 cycle.
  - Last B accepted -> first r_valid: 2 cycles.
- Engine interface rule: mul_en is never high in CLEAR or DRAIN; mul_rst_n is low only in the cycle after CLEAR and during reset.
- Arithmetic: no reduction in this block; results are the engine's CIPHERTEXT_WIDTH-bit truncated sums (mod 2^CIPHERTEXT_WIDTH).
- Back-to-back operations: an s_valid already high on return to IDLE starts CLEAR on the next cycle. Minimum 1 IDLE cycle between operations.
- s_data is ignored outside LOAD_A and LOAD_B.

Test Plan:
1. D=1, W=10, A=(3,5), B=(7,2), r_ready=1 -> r_data sequence 21, 41, 10 with r_index 0, 1, 2 and r_last on the third beat. busy returns to 0.
2. Wrap: A=(1000,1), B=(2,0) -> 976, 2, 0. Then immediately A=(1,1), B=(1,1) -> 1, 2, 1. This proves CLEAR wipes the prior accumulation.
3. Input gaps: s_valid toggled 1/0 every cycle during load -> mul_en pulses only on the cycles after accepted beats. Results are identical to scenario 1.
4. Backpressure: r_ready low for 3 cycles on each beat of scenario 1 -> r_data/r_index held stable, no beat lost or duplicated.
5. rst_n low for 1 cycle after the 2nd B beat is accepted -> next cycle: IDLE, busy=0, mul_rst_n=0, r_valid=0. A subsequent full run of scenario 1 yields 21, 41, 10.
6. Engine-port check on scenario 1 -> mul_(select,row,entry) sequence (0,0,3), (0,1,5), (1,0,7), (1,1,2), each with mul_en=1. It is preceded by exactly one mul_rst_n=0 cycle.
